tqvp_dlmiles_i2c_fifo_param: RTL and testbench

//  Parametrised TX/RX byte FIFO pair between the TinyQV peripheral register

---
 rtl/tqvp_dlmiles_i2c_fifo_param.sv | 161 ++++++++++++++++
 tb/tb_tqvp_dlmiles_i2c_fifo_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tqvp_dlmiles_i2c_fifo_param.sv
// TX {tag,data} and RX byte FIFOs between the TinyQV register interface and the I2C engine.
// Push visible at head next cycle; drop-on-full sets overrun; RX pop on empty sets underrun.
module tqvp_dlmiles_i2c_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int TX_TAG_WIDTH  = 1,
    parameter int TX_DEPTH_LOG2 = 2,
    parameter int RX_DEPTH_LOG2 = 2,
    parameter int RX_THRESH     = 2,
    parameter int TX_THRESH     = 1
) (
    input  logic                               clk,
    input  logic                               rst_i,
    input  logic                               tx_flush_i,
    input  logic                               rx_flush_i,
    input  logic                               flag_clr_i,
    input  logic [TX_TAG_WIDTH+DATA_WIDTH-1:0] cpu_tx_data_i,
    input  logic                               cpu_tx_valid_i,
    output logic                               cpu_tx_ready_o,
    output logic [TX_TAG_WIDTH+DATA_WIDTH-1:0] i2c_txd_data_o,
    output logic                               i2c_txd_valid_o,
    input  logic                               i2c_txd_ready_i,
    input  logic [DATA_WIDTH-1:0]              i2c_rxd_data_i,
    input  logic                               i2c_rxd_valid_i,
    output logic [DATA_WIDTH:0]                cpu_rx_data_o,
    output logic                               cpu_rx_valid_o,
    input  logic                               cpu_rx_ready_i,
    output logic [TX_DEPTH_LOG2:0]             tx_level_o,
    output logic [RX_DEPTH_LOG2:0]             rx_level_o,
    output logic                               st_tx_full_o,
    output logic                               st_tx_empty_o,
    output logic                               st_rx_full_o,
    output logic                               st_rx_empty_o,
    output logic                               st_tx_overrun_o,
    output logic                               st_rx_overrun_o,
    output logic                               st_rx_underrun_o,
    output logic                               irq_tx_thresh_o,
    output logic                               irq_rx_thresh_o
);
    localparam int TXW      = TX_TAG_WIDTH + DATA_WIDTH;
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;

    // ---------------- TX side ----------------
    logic [TXW-1:0]           tx_mem_q [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TX_DEPTH_LOG2:0]   tx_lvl_q, tx_lvl_d;
    logic                     tx_ovr_q, tx_ovr_d;
    logic                     tx_push, tx_pop;

    assign st_tx_empty_o   = (tx_lvl_q == '0);
    assign st_tx_full_o    = (tx_lvl_q == (TX_DEPTH_LOG2+1)'(TX_DEPTH));
    assign tx_level_o      = tx_lvl_q;
    assign cpu_tx_ready_o  = ~st_tx_full_o;
    assign i2c_txd_valid_o = ~st_tx_empty_o;
    assign i2c_txd_data_o  = st_tx_empty_o ? '0 : tx_mem_q[tx_rd_q];
    assign st_tx_overrun_o = tx_ovr_q;
    assign irq_tx_thresh_o = (32'(tx_lvl_q) <= TX_THRESH);

    // A pop frees the slot, so a push into a full FIFO still succeeds alongside it.
    assign tx_pop  = i2c_txd_ready_i & ~st_tx_empty_o;
    assign tx_push = cpu_tx_valid_i & (~st_tx_full_o | tx_pop);

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_lvl_d = tx_lvl_q;
        tx_ovr_d = tx_ovr_q;
        if (tx_flush_i) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_lvl_d = '0;
            tx_ovr_d = 1'b0;
        end else begin
            tx_ovr_d = (tx_ovr_q & ~flag_clr_i) | (cpu_tx_valid_i & ~tx_push);
            if (tx_push) tx_wr_d = tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_d = tx_rd_q + 1'b1;
            if (tx_push && !tx_pop)      tx_lvl_d = tx_lvl_q + 1'b1;
            else if (tx_pop && !tx_push) tx_lvl_d = tx_lvl_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_lvl_q <= '0;
            tx_ovr_q <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_lvl_q <= tx_lvl_d;
            tx_ovr_q <= tx_ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push && !tx_flush_i && !rst_i) tx_mem_q[tx_wr_q] <= cpu_tx_data_i;
    end

    // ---------------- RX side ----------------
    logic [DATA_WIDTH-1:0]    rx_mem_q [RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RX_DEPTH_LOG2:0]   rx_lvl_q, rx_lvl_d;
    logic                     rx_ovr_q, rx_ovr_d, rx_und_q, rx_und_d;
    logic                     rx_push, rx_pop;

    assign st_rx_empty_o    = (rx_lvl_q == '0);
    assign st_rx_full_o     = (rx_lvl_q == (RX_DEPTH_LOG2+1)'(RX_DEPTH));
    assign rx_level_o       = rx_lvl_q;
    assign cpu_rx_valid_o   = ~st_rx_empty_o;
    assign cpu_rx_data_o    = {st_rx_empty_o, st_rx_empty_o ? {DATA_WIDTH{1'b0}} : rx_mem_q[rx_rd_q]};
    assign st_rx_overrun_o  = rx_ovr_q;
    assign st_rx_underrun_o = rx_und_q;
    assign irq_rx_thresh_o  = (32'(rx_lvl_q) >= RX_THRESH);

    assign rx_pop  = cpu_rx_ready_i & ~st_rx_empty_o;
    assign rx_push = i2c_rxd_valid_i & (~st_rx_full_o | rx_pop);

    always_comb begin
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_lvl_d = rx_lvl_q;
        rx_ovr_d = rx_ovr_q;
        rx_und_d = rx_und_q;
        if (rx_flush_i) begin
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_lvl_d = '0;
            rx_ovr_d = 1'b0;
            rx_und_d = 1'b0;
        end else begin
            rx_ovr_d = (rx_ovr_q & ~flag_clr_i) | (i2c_rxd_valid_i & ~rx_push);
            rx_und_d = (rx_und_q & ~flag_clr_i) | (cpu_rx_ready_i & st_rx_empty_o);
            if (rx_push) rx_wr_d = rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_d = rx_rd_q + 1'b1;
            if (rx_push && !rx_pop)      rx_lvl_d = rx_lvl_q + 1'b1;
            else if (rx_pop && !rx_push) rx_lvl_d = rx_lvl_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_lvl_q <= '0;
            rx_ovr_q <= 1'b0;
            rx_und_q <= 1'b0;
        end else begin
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_lvl_q <= rx_lvl_d;
            rx_ovr_q <= rx_ovr_d;
            rx_und_q <= rx_und_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push && !rx_flush_i && !rst_i) rx_mem_q[rx_wr_q] <= i2c_rxd_data_i;
    end

endmodule

// File: tb/tb_tqvp_dlmiles_i2c_fifo_param.sv
// Directed bench for the I2C TX/RX FIFO pair with default parameters (8-bit data, 1 tag bit, depth 4).
module tb_tqvp_dlmiles_i2c_fifo_param;
    logic       clk = 1'b0;
    logic       rst_i, tx_flush_i, rx_flush_i, flag_clr_i;
    logic [8:0] cpu_tx_data_i;
    logic       cpu_tx_valid_i, cpu_tx_ready_o;
    logic [8:0] i2c_txd_data_o;
    logic       i2c_txd_valid_o, i2c_txd_ready_i;
    logic [7:0] i2c_rxd_data_i;
    logic       i2c_rxd_valid_i;
    logic [8:0] cpu_rx_data_o;
    logic       cpu_rx_valid_o, cpu_rx_ready_i;
    logic [2:0] tx_level_o, rx_level_o;
    logic       st_tx_full_o, st_tx_empty_o, st_rx_full_o, st_rx_empty_o;
    logic       st_tx_overrun_o, st_rx_overrun_o, st_rx_underrun_o;
    logic       irq_tx_thresh_o, irq_rx_thresh_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tqvp_dlmiles_i2c_fifo_param dut (
        .clk(clk), .rst_i(rst_i), .tx_flush_i(tx_flush_i), .rx_flush_i(rx_flush_i),
        .flag_clr_i(flag_clr_i), .cpu_tx_data_i(cpu_tx_data_i), .cpu_tx_valid_i(cpu_tx_valid_i),
        .cpu_tx_ready_o(cpu_tx_ready_o), .i2c_txd_data_o(i2c_txd_data_o),
        .i2c_txd_valid_o(i2c_txd_valid_o), .i2c_txd_ready_i(i2c_txd_ready_i),
        .i2c_rxd_data_i(i2c_rxd_data_i), .i2c_rxd_valid_i(i2c_rxd_valid_i),
        .cpu_rx_data_o(cpu_rx_data_o), .cpu_rx_valid_o(cpu_rx_valid_o),
        .cpu_rx_ready_i(cpu_rx_ready_i), .tx_level_o(tx_level_o), .rx_level_o(rx_level_o),
        .st_tx_full_o(st_tx_full_o), .st_tx_empty_o(st_tx_empty_o),
        .st_rx_full_o(st_rx_full_o), .st_rx_empty_o(st_rx_empty_o),
        .st_tx_overrun_o(st_tx_overrun_o), .st_rx_overrun_o(st_rx_overrun_o),
        .st_rx_underrun_o(st_rx_underrun_o), .irq_tx_thresh_o(irq_tx_thresh_o),
        .irq_rx_thresh_o(irq_rx_thresh_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Step one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tx_push(input logic [8:0] d);
        cpu_tx_data_i = d; cpu_tx_valid_i = 1'b1; tick(); cpu_tx_valid_i = 1'b0;
    endtask

    task automatic tx_pop();
        i2c_txd_ready_i = 1'b1; tick(); i2c_txd_ready_i = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        i2c_rxd_data_i = d; i2c_rxd_valid_i = 1'b1; tick(); i2c_rxd_valid_i = 1'b0;
    endtask

    task automatic rx_pop();
        cpu_rx_ready_i = 1'b1; tick(); cpu_rx_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; tx_flush_i = 1'b0; rx_flush_i = 1'b0; flag_clr_i = 1'b0;
        cpu_tx_data_i = '0; cpu_tx_valid_i = 1'b0; i2c_txd_ready_i = 1'b0;
        i2c_rxd_data_i = '0; i2c_rxd_valid_i = 1'b0; cpu_rx_ready_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;

        chk("rst_tx_level", 32'(tx_level_o), 0);
        chk("rst_tx_empty", 32'(st_tx_empty_o), 1);
        chk("rst_tx_full", 32'(st_tx_full_o), 0);
        chk("rst_tx_ready", 32'(cpu_tx_ready_o), 1);
        chk("rst_txd_valid", 32'(i2c_txd_valid_o), 0);
        chk("rst_txd_data", 32'(i2c_txd_data_o), 0);
        chk("rst_rx_data", 32'(cpu_rx_data_o), 32'h100);
        chk("rst_rx_valid", 32'(cpu_rx_valid_o), 0);
        chk("rst_rx_empty", 32'(st_rx_empty_o), 1);
        chk("rst_flags", {29'd0, st_tx_overrun_o, st_rx_overrun_o, st_rx_underrun_o}, 0);
        chk("rst_irq_tx", 32'(irq_tx_thresh_o), 1);
        chk("rst_irq_rx", 32'(irq_rx_thresh_o), 0);

        // 1: fill TX, overrun on drop, drain in order
        tx_push(9'h0A1);
        chk("t1_irq_tx_lvl1", 32'(irq_tx_thresh_o), 1);
        chk("t1_head_lat", 32'(i2c_txd_data_o), 32'h0A1);
        tx_push(9'h0A2);
        chk("t1_irq_tx_lvl2", 32'(irq_tx_thresh_o), 0);
        tx_push(9'h0A3);
        tx_push(9'h0A4);
        chk("t1_level4", 32'(tx_level_o), 4);
        chk("t1_full", 32'(st_tx_full_o), 1);
        chk("t1_ready0", 32'(cpu_tx_ready_o), 0);
        tx_push(9'h055);
        chk("t1_level_drop", 32'(tx_level_o), 4);
        chk("t1_overrun", 32'(st_tx_overrun_o), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t1_drain", 32'(i2c_txd_data_o), 32'h0A0 + i);
            tx_pop();
        end
        chk("t1_empty", 32'(st_tx_empty_o), 1);
        chk("t1_valid0", 32'(i2c_txd_valid_o), 0);
        chk("t1_data0", 32'(i2c_txd_data_o), 0);

        // 2: alternating RX push/pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            rx_push(8'(8'h10 + i));
            chk("t2_head", 32'(cpu_rx_data_o), 32'h010 + i);
            chk("t2_level1", 32'(rx_level_o), 1);
            rx_pop();
            chk("t2_level0", 32'(rx_level_o), 0);
        end
        chk("t2_ovr", 32'(st_rx_overrun_o), 0);
        chk("t2_und", 32'(st_rx_underrun_o), 0);

        // 3: push+pop while full, then push+pop while empty
        for (int i = 0; i < 4; i++) rx_push(8'(8'h20 + i));
        chk("t3_full", 32'(st_rx_full_o), 1);
        i2c_rxd_data_i = 8'h77; i2c_rxd_valid_i = 1'b1; cpu_rx_ready_i = 1'b1;
        tick();
        i2c_rxd_valid_i = 1'b0; cpu_rx_ready_i = 1'b0;
        chk("t3_level4", 32'(rx_level_o), 4);
        chk("t3_no_ovr", 32'(st_rx_overrun_o), 0);
        chk("t3_d0", 32'(cpu_rx_data_o), 32'h021); rx_pop();
        chk("t3_d1", 32'(cpu_rx_data_o), 32'h022); rx_pop();
        chk("t3_d2", 32'(cpu_rx_data_o), 32'h023); rx_pop();
        chk("t3_d3", 32'(cpu_rx_data_o), 32'h077); rx_pop();
        chk("t3_empty", 32'(st_rx_empty_o), 1);
        i2c_rxd_data_i = 8'h88; i2c_rxd_valid_i = 1'b1; cpu_rx_ready_i = 1'b1;
        tick();
        i2c_rxd_valid_i = 1'b0; cpu_rx_ready_i = 1'b0;
        chk("t3_empty_pp_lvl", 32'(rx_level_o), 1);
        chk("t3_empty_pp_head", 32'(cpu_rx_data_o), 32'h088);
        rx_flush_i = 1'b1; tick(); rx_flush_i = 1'b0;
        chk("t3_flush_lvl", 32'(rx_level_o), 0);
        chk("t3_flush_und", 32'(st_rx_underrun_o), 0);

        // 4: RX threshold rises at level 2, falls at level 1
        rx_push(8'h01);
        chk("t4_irq_lvl1", 32'(irq_rx_thresh_o), 0);
        rx_push(8'h02);
        chk("t4_irq_lvl2", 32'(irq_rx_thresh_o), 1);
        rx_pop();
        chk("t4_irq_fall", 32'(irq_rx_thresh_o), 0);
        chk("t4_irq_tx", 32'(irq_tx_thresh_o), 1);
        rx_pop();
        chk("t4_rx_empty", 32'(rx_level_o), 0);

        // 5: TX flush with concurrent push; RX untouched
        rx_push(8'h33);
        tx_push(9'h1B1); tx_push(9'h1B2); tx_push(9'h1B3);
        chk("t5_level3", 32'(tx_level_o), 3);
        chk("t5_tag_head", 32'(i2c_txd_data_o), 32'h1B1);
        chk("t5_irq_tx0", 32'(irq_tx_thresh_o), 0);
        chk("t5_ovr_before", 32'(st_tx_overrun_o), 1);
        tx_flush_i = 1'b1; cpu_tx_data_i = 9'h0FF; cpu_tx_valid_i = 1'b1;
        tick();
        tx_flush_i = 1'b0; cpu_tx_valid_i = 1'b0;
        chk("t5_flush_lvl", 32'(tx_level_o), 0);
        chk("t5_flush_empty", 32'(st_tx_empty_o), 1);
        chk("t5_flush_ovr", 32'(st_tx_overrun_o), 0);
        chk("t5_flush_valid", 32'(i2c_txd_valid_o), 0);
        chk("t5_rx_lvl", 32'(rx_level_o), 1);
        chk("t5_rx_data", 32'(cpu_rx_data_o), 32'h033);
        rx_pop();

        // 6: underrun and sticky clear precedence
        rx_pop();
        chk("t6_und", 32'(st_rx_underrun_o), 1);
        chk("t6_data", 32'(cpu_rx_data_o), 32'h100);
        flag_clr_i = 1'b1; cpu_rx_ready_i = 1'b1;
        tick();
        flag_clr_i = 1'b0; cpu_rx_ready_i = 1'b0;
        chk("t6_clr_vs_evt", 32'(st_rx_underrun_o), 1);
        flag_clr_i = 1'b1; tick(); flag_clr_i = 1'b0;
        chk("t6_clr", 32'(st_rx_underrun_o), 0);
        chk("t6_rx_ovr", 32'(st_rx_overrun_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
